mo_mul_pipe: RTL and testbench
==============================

// Module: mo_mul_pipe
// PURPOSE
//  Pipelined radix-2^R_BITS Montgomery multiplier with valid/tag side-band, global stall and fully reduced output.
//  Computes result = a*b*2^-WIDTH mod Q, with result always in [0,Q).
//  Drop-in butterfly multiplier for the NTT datapath (Kyber/Dilithium), replacing the fixed radix-2, handshake-free multiplier.
//  Accepts one operand pair per enabled cycle.
// PARAMETERS
//  WIDTH      `DATA_WIDTH  operand/result width; 2^WIDTH > Q
//  Q          `Q           odd modulus (3329 Kyber, 8380417 Dilithium)
//  R_BITS     1            bits of b consumed per stage; WIDTH % R_BITS == 0 (elaboration error otherwise)
//  TAG_WIDTH  8            side-band tag carried alongside data (coefficient index/bank id)
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          asynchronous active-low reset
//  en         in   1          pipeline advance; 0 = every register holds
//  in_valid   in   1          a/b/in_tag valid this cycle (sampled only when en=1)
//  a          in   WIDTH      multiplicand, must be < Q
//  b          in   WIDTH      multiplier, must be < Q
//  in_tag     in   TAG_WIDTH  tag, returned unchanged with the result
//  out_valid  out  1          result/out_tag valid
//  result     out  WIDTH      a*b*2^-WIDTH mod Q, in [0,Q)
//  out_tag    out  TAG_WIDTH  tag of the operands that produced result
// BEHAVIOUR
//  - Constants: STAGES = WIDTH/R_BITS; LAT = STAGES+1; QINV = -Q^-1 mod 2^R_BITS, computed at elaboration.
//  - Reset (async assert, sync deassert on clk): every stage valid bit = 0; out_valid = 0; result = 0; out_tag = 0.
//    Data registers of non-output stages need no reset.
//  - Stage i, i = 0..STAGES-1, with t_0 = 0:
//      d = b[i*R_BITS +: R_BITS]; u = t_i + d*a; m = (u[R_BITS-1:0]*QINV) mod 2^R_BITS; t_{i+1} = (u + m*Q) >> R_BITS.
//    Arithmetic is unsigned; accumulator width = WIDTH+R_BITS+2. Invariant t < 2Q holds for a,b < Q.
//  - Final stage: result = (t >= Q) ? t-Q : t. Single conditional subtract; no second correction.
//  - a, b and tag travel with their stage; each stage holds its own copy of b's unused digits (no shared storage).
//  - Latency: a transaction accepted at enabled edge N appears with out_valid=1 after LAT enabled edges.
//    Disabled cycles add delay but never drop, duplicate or reorder transactions.
//  - en=0: all data, tag and valid registers hold; out_valid/result/out_tag stay constant.
//  - in_valid=0 with en=1: a bubble propagates (valid 0). Data registers may hold garbage but out_tag/result
//    change only when a valid transaction lands (power: gate data regs with stage valid).
//  - Back-to-back valid every cycle: throughput 1/cycle, no dead cycles.
//  - Reset mid-operation: all in-flight transactions discarded; out_valid=0 the cycle after assertion.
//    Nothing from before reset ever emerges.
//  - Operand >= Q: result undefined but must still be WIDTH bits, with valid/tag timing unaffected.
// STRUCTURE
//  - ntt_pkg (existing shared header): Q, DATA_WIDTH, function mont_qinv(q, r_bits), typedef mo_mul_stage_t
//    {valid, a, b, t, tag}, parametrised by width.
//  - Sub-module mo_mul_stage: one radix-2^R_BITS step (comb step + register with en); instantiated STAGES times
//    by generate. The final correction register is local to mo_mul_pipe.
//  - No FSM. Control is the valid shift chain qualified by en.
// TESTING  (Q=3329, WIDTH=12 unless stated; R_BITS swept over 1,2,3,4,6)
//  1. a=1, b=767 (2^12 mod Q) -> result=1, out_valid exactly LAT cycles after in_valid.
//  2. a=3328, b=3328 -> result=2704 (=2^-12 mod Q); a=0, b=3328 -> 0; a=3328, b=0 -> 0.
//  3. 1000 back-to-back random pairs with tag=index -> every result equals golden model; tags in order; no gaps.
//  4. Random en toggling (50%) with random in_valid -> output sequence identical to the no-stall run;
//     out_* constant while en=0.
//  5. Assert rst_n low for 1 cycle with 5 transactions in flight -> out_valid=0 immediately; none of the 5 ever
//     emerges; next input emerges after LAT.
//  6. Q=8380417, WIDTH=23, R_BITS=1 -> a=1, b=2^23 mod Q (=8191) gives 1; exhaustive-random 1e5 vs model,
//     result < Q always.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared NTT datapath definitions: default modulus, widths and
// the Montgomery constant helper used by the multiplier pipeline.
package ntt_pkg;

    localparam int unsigned NTT_Q          = 3329;
    localparam int unsigned NTT_DATA_WIDTH = 12;
    localparam int unsigned NTT_TAG_WIDTH  = 8;

    // Stage bundle for the default datapath width; modules with
    // other widths declare the same layout locally.
    typedef struct packed {
        logic                      valid;
        logic [NTT_DATA_WIDTH-1:0] a;
        logic [NTT_DATA_WIDTH-1:0] b;
        logic [NTT_DATA_WIDTH:0]   t;
        logic [NTT_TAG_WIDTH-1:0]  tag;
    } mo_mul_stage_t;

    // -q^-1 mod 2^r_bits for odd q. Newton iteration doubles the
    // number of correct low bits each pass, starting from 3 bits.
    function automatic int unsigned mont_qinv(
        input int unsigned q,
        input int unsigned r_bits
    );
        longint unsigned qq;
        longint unsigned inv;
        longint unsigned mask;
        qq   = 64'(q);
        inv  = qq;
        for (int i = 0; i < 5; i++) begin
            inv = inv * (64'd2 - qq * inv);
        end
        mask = (64'd1 << r_bits) - 64'd1;
        return 32'((~inv + 64'd1) & mask);
    endfunction

endpackage

// File: rtl/mo_mul_stage.sv
// One radix-2^R_BITS Montgomery step: folds digit IDX of b into
// the accumulator and registers the bundle when the pipe advances.
module mo_mul_stage
    import ntt_pkg::*;
#(
    parameter int unsigned WIDTH     = NTT_DATA_WIDTH,
    parameter int unsigned Q         = NTT_Q,
    parameter int unsigned R_BITS    = 1,
    parameter int unsigned TAG_WIDTH = NTT_TAG_WIDTH,
    parameter int unsigned IDX       = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [WIDTH:0]       t_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 valid_o,
    output logic [WIDTH-1:0]     a_o,
    output logic [WIDTH-1:0]     b_o,
    output logic [WIDTH:0]       t_o,
    output logic [TAG_WIDTH-1:0] tag_o
);

    localparam int unsigned AW = WIDTH + R_BITS + 2;
    localparam logic [R_BITS-1:0] QINV =
        R_BITS'(mont_qinv(Q, R_BITS));
    localparam logic [AW-1:0] QW = AW'(Q);

    logic [R_BITS-1:0]    d;
    logic [AW-1:0]        u;
    logic [R_BITS-1:0]    m;
    logic [AW-1:0]        s;
    logic [WIDTH:0]       t_d;

    logic                 valid_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH:0]       t_q;
    logic [TAG_WIDTH-1:0] tag_q;

    // t' = (t + d*a + m*Q) / 2^R with m chosen to clear the low digit
    always_comb begin
        d   = b_i[IDX*R_BITS +: R_BITS];
        u   = AW'(t_i) + AW'(d) * AW'(a_i);
        m   = u[R_BITS-1:0] * QINV;
        s   = u + AW'(m) * QW;
        t_d = (WIDTH+1)'(s >> R_BITS);
    end

    // stage occupancy bit, the only control state in the stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (en) begin
            valid_q <= valid_i;
        end
    end

    // data only moves for real transactions to keep bubbles quiet
    always_ff @(posedge clk) begin
        if (en && valid_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            t_q   <= t_d;
            tag_q <= tag_i;
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign t_o     = t_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/mo_mul_pipe.sv
// Pipelined Montgomery multiplier: result = a*b*2^-WIDTH mod Q,
// one operand pair per enabled cycle, tag carried alongside.
module mo_mul_pipe
    import ntt_pkg::*;
#(
    parameter int unsigned WIDTH     = NTT_DATA_WIDTH,
    parameter int unsigned Q         = NTT_Q,
    parameter int unsigned R_BITS    = 1,
    parameter int unsigned TAG_WIDTH = NTT_TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     result,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int unsigned STAGES = WIDTH / R_BITS;
    localparam logic [WIDTH:0] QE = (WIDTH+1)'(Q);

    typedef struct packed {
        logic                 valid;
        logic [WIDTH-1:0]     a;
        logic [WIDTH-1:0]     b;
        logic [WIDTH:0]       t;
        logic [TAG_WIDTH-1:0] tag;
    } stage_t;

    if (WIDTH % R_BITS != 0) begin : g_bad_radix
        $error("mo_mul_pipe: WIDTH must be a multiple of R_BITS");
    end
    if (Q % 2 == 0) begin : g_bad_q
        $error("mo_mul_pipe: Q must be odd");
    end

    stage_t [STAGES:0] pipe;

    assign pipe[0].valid = in_valid;
    assign pipe[0].a     = a;
    assign pipe[0].b     = b;
    assign pipe[0].t     = '0;
    assign pipe[0].tag   = in_tag;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        mo_mul_stage #(
            .WIDTH    (WIDTH),
            .Q        (Q),
            .R_BITS   (R_BITS),
            .TAG_WIDTH(TAG_WIDTH),
            .IDX      (g)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .valid_i(pipe[g].valid),
            .a_i    (pipe[g].a),
            .b_i    (pipe[g].b),
            .t_i    (pipe[g].t),
            .tag_i  (pipe[g].tag),
            .valid_o(pipe[g+1].valid),
            .a_o    (pipe[g+1].a),
            .b_o    (pipe[g+1].b),
            .t_o    (pipe[g+1].t),
            .tag_o  (pipe[g+1].tag)
        );
    end

    // operand copies leaving the last stage have no consumer
    logic unused_tail;
    assign unused_tail = ^{pipe[STAGES].a, pipe[STAGES].b};

    logic [WIDTH:0]       t_fin;
    logic [WIDTH-1:0]     result_d;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     result_q;
    logic [TAG_WIDTH-1:0] out_tag_q;

    // t < 2Q, so one conditional subtract fully reduces
    always_comb begin
        t_fin = pipe[STAGES].t;
        if (t_fin >= QE) begin
            result_d = WIDTH'(t_fin - QE);
        end else begin
            result_d = WIDTH'(t_fin);
        end
    end

    // output register; result/tag change only on a valid landing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_tag_q   <= '0;
        end else if (en) begin
            out_valid_q <= pipe[STAGES].valid;
            if (pipe[STAGES].valid) begin
                result_q  <= result_d;
                out_tag_q <= pipe[STAGES].tag;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_mo_mul_pipe.sv
// Bench for mo_mul_pipe: five Kyber radix variants plus one
// Dilithium instance, checked every cycle against a modular model.
module tb_mo_mul_pipe;

    localparam int NI = 5;
    localparam int KQ = 3329;
    localparam int DQ = 8380417;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [11:0] a;
    logic [11:0] b;
    logic [7:0]  in_tag;
    logic        ov_k  [NI];
    logic [11:0] res_k [NI];
    logic [7:0]  tag_k [NI];

    logic        en_d;
    logic        v_d;
    logic [22:0] a_d;
    logic [22:0] b_d;
    logic [7:0]  tag_in_d;
    logic        ov_d;
    logic [22:0] res_d;
    logic [7:0]  tag_d;

    function automatic int rb_of(int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            default: return 6;
        endcase
    endfunction

    function automatic int lat_of(int k);
        if (k < NI) return 12 / rb_of(k) + 1;
        return 24;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mo_mul_pipe #(
            .WIDTH(12), .Q(KQ), .R_BITS(rb_of(g)), .TAG_WIDTH(8)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .en(en),
            .in_valid(in_valid), .a(a), .b(b), .in_tag(in_tag),
            .out_valid(ov_k[g]), .result(res_k[g]),
            .out_tag(tag_k[g])
        );
    end

    mo_mul_pipe #(
        .WIDTH(23), .Q(DQ), .R_BITS(1), .TAG_WIDTH(8)
    ) u_dil (
        .clk(clk), .rst_n(rst_n), .en(en_d),
        .in_valid(v_d), .a(a_d), .b(b_d), .in_tag(tag_in_d),
        .out_valid(ov_d), .result(res_d), .out_tag(tag_d)
    );

    // a*b*2^-w mod q: reduce the product, then halve mod q w times
    function automatic longint unsigned mont(
        longint unsigned x, longint unsigned y,
        longint unsigned q, int w
    );
        longint unsigned p;
        p = (x * y) % q;
        for (int i = 0; i < w; i++) begin
            p = p[0] ? (p + q) >> 1 : p >> 1;
        end
        return p;
    endfunction

    typedef struct {
        logic            v;
        longint unsigned r;
        logic [7:0]      tag;
    } ent_t;

    // per-instance history of the last LAT enabled edges
    ent_t            mq     [NI+1][$];
    longint unsigned last_r [NI+1];
    logic [7:0]      last_t [NI+1];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int probe_cyc [NI+1];
    bit armed     [NI+1];
    bit seen      [NI+1];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s @cyc %0d: got %0d, want %0d",
                         nm, cyc, act, exp);
        end
    endtask

    // model: output after an enabled edge is the input LAT edges ago
    always @(posedge clk) begin
        ent_t e;
        logic ek;
        if (!rst_n) begin
            for (int k = 0; k <= NI; k++) begin
                mq[k].delete();
                last_r[k] = 0;
                last_t[k] = '0;
            end
        end else begin
            for (int k = 0; k <= NI; k++) begin
                if (k < NI) begin
                    ek    = en;
                    e.v   = in_valid;
                    e.r   = mont(64'(a), 64'(b), KQ, 12);
                    e.tag = in_tag;
                end else begin
                    ek    = en_d;
                    e.v   = v_d;
                    e.r   = mont(64'(a_d), 64'(b_d), DQ, 23);
                    e.tag = tag_in_d;
                end
                if (ek) begin
                    mq[k].push_back(e);
                    if (mq[k].size() > lat_of(k))
                        void'(mq[k].pop_front());
                    if (mq[k].size() == lat_of(k) && mq[k][0].v) begin
                        last_r[k] = mq[k][0].r;
                        last_t[k] = mq[k][0].tag;
                    end
                end
            end
        end
    end

    // compare every DUT output against the model on the falling edge
    always @(negedge clk) begin
        logic            o_v;
        logic [63:0]     o_r;
        logic [7:0]      o_t;
        logic            x_v;
        logic [63:0]     x_r;
        logic [7:0]      x_t;
        logic            i_v;
        logic            i_e;
        logic [7:0]      i_t;
        logic [7:0]      ptag;
        cyc++;
        if (cyc == 2) begin
            chk("model 1*767", mont(1, 767, KQ, 12), 1);
            chk("model 3328^2", mont(3328, 3328, KQ, 12), 2704);
            chk("model 0*3328", mont(0, 3328, KQ, 12), 0);
            chk("model 3328*0", mont(3328, 0, KQ, 12), 0);
            chk("model dil 1*8191", mont(1, 8191, DQ, 23), 1);
        end
        for (int k = 0; k <= NI; k++) begin
            if (k < NI) begin
                o_v = ov_k[k];
                o_r = 64'(res_k[k]);
                o_t = tag_k[k];
                i_v = in_valid;
                i_e = en;
                i_t = in_tag;
                ptag = 8'hA5;
            end else begin
                o_v = ov_d;
                o_r = 64'(res_d);
                o_t = tag_d;
                i_v = v_d;
                i_e = en_d;
                i_t = tag_in_d;
                ptag = 8'h5A;
            end
            if (!rst_n) begin
                x_v = 1'b0;
                x_r = '0;
                x_t = '0;
            end else begin
                x_v = (mq[k].size() == lat_of(k)) ? mq[k][0].v : 1'b0;
                x_r = 64'(last_r[k]);
                x_t = last_t[k];
            end
            chk($sformatf("out_valid[%0d]", k), 64'(o_v), 64'(x_v));
            chk($sformatf("result[%0d]", k), o_r, x_r);
            chk($sformatf("out_tag[%0d]", k), 64'(o_t), 64'(x_t));
            if (armed[k] && !seen[k]) begin
                if (o_v && o_t == ptag) begin
                    seen[k] = 1'b1;
                    chk($sformatf("probe latency[%0d]", k),
                        64'(cyc - probe_cyc[k]), 64'(lat_of(k)));
                    chk($sformatf("probe result[%0d]", k), o_r, 1);
                end else if (cyc - probe_cyc[k] > 40) begin
                    seen[k] = 1'b1;
                    chk($sformatf("probe timeout[%0d]", k), 0, 1);
                end
            end
            if (!armed[k] && rst_n && i_e && i_v && i_t == ptag) begin
                armed[k]     = 1'b1;
                probe_cyc[k] = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        v_d      = ($urandom_range(9) != 0);
        a_d      = 23'($urandom_range(DQ - 1));
        b_d      = 23'($urandom_range(DQ - 1));
        tag_in_d = 8'($urandom_range(255));
    endtask

    task automatic drive(int x, int y, int t);
        in_valid = 1'b1;
        a        = 12'(x);
        b        = 12'(y);
        in_tag   = 8'(t);
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b1; in_valid = 1'b0; a = '0; b = '0; in_tag = '0;
        en_d = 1'b1; v_d = 1'b0; a_d = '0; b_d = '0; tag_in_d = '0;
        repeat (3) step();
        rst_n = 1'b1;
        drive(1, 767, 8'hA5);
        v_d = 1'b1; a_d = 23'd1; b_d = 23'd8191; tag_in_d = 8'h5A;
        step();
        idle(40);

        drive(3328, 3328, 1); step();
        drive(0, 3328, 2);    step();
        drive(3328, 0, 3);    step();
        idle(20);

        for (int i = 0; i < 1000; i++) begin
            drive($urandom_range(KQ - 1), $urandom_range(KQ - 1), i);
            step();
        end
        idle(20);

        for (int i = 0; i < 1000; i++) begin
            en = 1'($urandom_range(1));
            drive($urandom_range(KQ - 1), $urandom_range(KQ - 1),
                  $urandom_range(255));
            in_valid = 1'($urandom_range(1));
            step();
        end
        en = 1'b1;
        idle(30);

        for (int i = 0; i < 5; i++) begin
            drive($urandom_range(KQ - 1), $urandom_range(KQ - 1),
                  8'hE0 + i);
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(1234, 2345, 8'h77);
        step();
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
